fifo_reader: RTL and testbench

FIFO_READER -- requirements
Module: fifo_reader

---
 rtl/fifo_pkg.sv | 13 +
 rtl/fifo_reader_skid.sv | 58 +++++
 rtl/fifo_reader.sv | 54 +++++
 tb/tb_fifo_reader.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared occupancy type, latency/depth constants and default widths
// for the FIFO-to-stream reader.
package fifo_pkg;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} occ_e;
  localparam int RD_LAT     = 1;
  localparam int BUF_DEPTH  = 2;
  localparam int DWIDTH_DEF = 8;
  localparam int AWIDTH_DEF = 4;
  localparam int CWIDTH_DEF = 16;
  function automatic int occ_cnt(occ_e s);
    return s == TWO ? 2 : s == ONE ? 1 : 0;
  endfunction
endpackage

// File: rtl/fifo_reader_skid.sv
// fifo_reader_skid: two-entry output buffer; head drives the stream, tail
// absorbs the word that lands while the sink is stalled.
module fifo_reader_skid
  import fifo_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF
) (
  input  logic              clk_i,
  input  logic              arstn_i,
  input  logic              cap_i,
  input  logic [DWIDTH-1:0] wdata_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [DWIDTH-1:0] data_o,
  output occ_e              state_o
);
  occ_e state_q, state_d;
  logic [DWIDTH-1:0] head_q, head_d, tail_q, tail_d;
  logic hs;
  assign valid_o = state_q != EMPTY;
  assign data_o  = head_q;
  assign state_o = state_q;
  always_comb begin
    hs      = valid_o & ready_i;
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      EMPTY: if (cap_i) begin
        state_d = ONE;
        head_d  = wdata_i;
      end
      ONE: if (cap_i && hs) head_d = wdata_i;
      else if (cap_i) begin
        state_d = TWO;
        tail_d  = wdata_i;
      end else if (hs) state_d = EMPTY;
      TWO: if (hs) begin
        // credit logic keeps capture out of TWO; handled anyway to stay ordered
        state_d = cap_i ? TWO : ONE;
        head_d  = tail_q;
        tail_d  = cap_i ? wdata_i : tail_q;
      end
      default: state_d = EMPTY;
    endcase
  end
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end
endmodule

// File: rtl/fifo_reader.sv
// fifo_reader: pops a registered-output FIFO into a valid/ready stream with
// credit-based pop control and a saturating delivered-word counter.
module fifo_reader
  import fifo_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int AWIDTH = AWIDTH_DEF,
  parameter int CWIDTH = CWIDTH_DEF
) (
  input  logic              clk_i,
  input  logic              arstn_i,
  output logic              rd_o,
  output logic [AWIDTH-1:0] shift_o,
  input  logic              empty_i,
  input  logic [DWIDTH-1:0] rddata_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DWIDTH-1:0] data_o,
  output logic [CWIDTH-1:0] cnt_o
);
  logic infl_q, infl_d;
  logic [CWIDTH-1:0] cnt_q, cnt_d;
  logic hs;
  occ_e state;
  fifo_reader_skid #(.DWIDTH(DWIDTH)) u_skid (
    .clk_i   (clk_i),
    .arstn_i (arstn_i),
    .cap_i   (infl_q),
    .wdata_i (rddata_i),
    .ready_i (ready_i),
    .valid_o (valid_o),
    .data_o  (data_o),
    .state_o (state)
  );
  assign shift_o = AWIDTH'(1);
  assign cnt_o   = cnt_q;
  always_comb begin
    hs     = valid_o & ready_i;
    // a pop is only issued if its word is guaranteed a slot when it lands
    rd_o   = arstn_i && !empty_i &&
             (occ_cnt(state) + int'(infl_q) - int'(hs) < BUF_DEPTH);
    infl_d = rd_o;
    cnt_d  = (hs && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      infl_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      infl_q <= infl_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

// File: tb/tb_fifo_reader.sv
// tb_fifo_reader: FIFO environment plus queue-based reference of the stream
// reader, checked every cycle, with directed scenarios pinned by literals.
module tb_fifo_reader;
  localparam int DW = 8, AW = 4, CW = 16;
  logic clk = 0, arstn_i = 1, empty_i = 1, ready_i = 0;
  logic [DW-1:0] rddata_i = '0;
  logic rd_o, valid_o, rd4, valid4;
  logic [AW-1:0] shift_o, shift4;
  logic [DW-1:0] data_o, data4;
  logic [CW-1:0] cnt_o;
  logic [3:0] cnt4;
  int checks = 0, failures = 0, cyc = 0;
  logic [DW-1:0] fq[$], bq[$], dlog[$];
  int dcyc[$], pcyc[$];
  bit infl = 0;
  logic [DW-1:0] infl_w = '0;
  int mcnt = 0, mcnt4 = 0;
  bit s_rd = 0, s_empty = 1, s_ready = 0;
  int guard;

  always #5 clk = ~clk;

  fifo_reader #(.DWIDTH(DW), .AWIDTH(AW), .CWIDTH(CW)) dut (
    .clk_i(clk), .arstn_i(arstn_i), .rd_o(rd_o), .shift_o(shift_o),
    .empty_i(empty_i), .rddata_i(rddata_i), .valid_o(valid_o),
    .ready_i(ready_i), .data_o(data_o), .cnt_o(cnt_o));

  fifo_reader #(.DWIDTH(DW), .AWIDTH(AW), .CWIDTH(4)) dut4 (
    .clk_i(clk), .arstn_i(arstn_i), .rd_o(rd4), .shift_o(shift4),
    .empty_i(empty_i), .rddata_i(rddata_i), .valid_o(valid4),
    .ready_i(ready_i), .data_o(data4), .cnt_o(cnt4));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
    end
  endtask

  // words held + word in flight - word leaving must stay below two
  function automatic bit exp_rd();
    return !empty_i && (bq.size() + int'(infl) - int'(bq.size() > 0 && ready_i) < 2);
  endfunction

  always @(negedge clk) begin
    if (!arstn_i) begin
      s_rd    <= 0;
      s_ready <= 0;
      s_empty <= 1;
    end else begin
      chk("rd_o", rd_o, exp_rd());
      chk("rd_o_c4", rd4, exp_rd());
      chk("valid_o", valid_o, bq.size() > 0);
      chk("valid_o_c4", valid4, bq.size() > 0);
      if (bq.size() > 0) begin
        chk("data_o", data_o, bq[0]);
        chk("data_o_c4", data4, bq[0]);
      end
      chk("cnt_o", cnt_o, mcnt);
      chk("cnt_o_c4", cnt4, mcnt4);
      chk("shift_o", shift_o, 1);
      s_rd    <= rd_o;
      s_empty <= empty_i;
      s_ready <= ready_i;
      if (rd_o && !empty_i) pcyc.push_back(cyc);
      if (valid_o && ready_i) begin
        dlog.push_back(data_o);
        dcyc.push_back(cyc);
      end
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (s_ready && bq.size() > 0) begin
        void'(bq.pop_front());
        if (mcnt < 65535) mcnt++;
        if (mcnt4 < 15) mcnt4++;
      end
      if (infl) bq.push_back(infl_w);
      infl = s_rd && !s_empty;
      if (infl) begin
        infl_w   = fq.pop_front();
        rddata_i = infl_w;
      end else rddata_i = DW'($urandom);
      empty_i = fq.size() == 0;
    end
  endtask

  task automatic put(input logic [DW-1:0] v);
    fq.push_back(v);
    empty_i = 0;
  endtask

  task automatic rst_checks(input string tag);
    chk({tag, "_valid"}, valid_o, 0);
    chk({tag, "_rd"}, rd_o, 0);
    chk({tag, "_data"}, data_o, 0);
    chk({tag, "_cnt"}, cnt_o, 0);
    chk({tag, "_cnt_c4"}, cnt4, 0);
    chk({tag, "_shift"}, shift_o, 1);
  endtask

  task automatic clear_logs();
    dlog.delete();
    dcyc.delete();
    pcyc.delete();
  endtask

  initial begin
    #1 arstn_i = 0;
    #1 rst_checks("por");
    tick(2);
    #2 arstn_i = 1;
    tick(1);
    // three preloaded words at full rate
    put(8'h11); put(8'h22); put(8'h33);
    ready_i = 1;
    tick(8);
    chk("p3_n", dlog.size(), 3);
    chk("p3_w0", dlog[0], 8'h11);
    chk("p3_w1", dlog[1], 8'h22);
    chk("p3_w2", dlog[2], 8'h33);
    chk("p3_b2b1", dcyc[1] - dcyc[0], 1);
    chk("p3_b2b2", dcyc[2] - dcyc[0], 2);
    chk("p3_lat", dcyc[0] - pcyc[0], 2);
    chk("p3_cnt", cnt_o, 3);
    chk("p3_valid", valid_o, 0);
    // stalled sink: only two pops may be outstanding
    clear_logs();
    ready_i = 0;
    for (int i = 0; i < 5; i++) put(8'h51 + 8'(i));
    tick(10);
    chk("stall_pops", pcyc.size(), 2);
    chk("stall_valid", valid_o, 1);
    chk("stall_data", data_o, 8'h51);
    ready_i = 1;
    tick(10);
    chk("stall_n", dlog.size(), 5);
    for (int i = 0; i < 5; i++) chk("stall_w", dlog[i], 8'h51 + 8'(i));
    // sink ready every other cycle
    clear_logs();
    ready_i = 0;
    for (int i = 0; i < 8; i++) put(8'h81 + 8'(i));
    for (int i = 0; i < 24; i++) begin
      ready_i = (i % 2) == 0;
      tick(1);
    end
    chk("alt_n", dlog.size(), 8);
    for (int i = 0; i < 8; i++) chk("alt_w", dlog[i], 8'h81 + 8'(i));
    chk("alt_cnt", cnt_o, 16);
    chk("alt_cnt_sat", cnt4, 15);
    // random traffic
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 9) < 4) put(DW'($urandom));
      ready_i = $urandom_range(0, 3) != 0;
      tick(1);
    end
    chk("rnd_cnt_sat", cnt4, 15);
    // drain, then reset while streaming with a pop in flight
    ready_i = 1;
    guard = 0;
    while ((fq.size() != 0 || bq.size() != 0 || infl) && guard < 300) begin
      tick(1);
      guard++;
    end
    chk("drain_timeout", guard < 300, 1);
    tick(2);
    chk("drain_valid", valid_o, 0);
    for (int i = 0; i < 6; i++) put(8'hC1 + 8'(i));
    tick(4);
    chk("pre_rst_valid", valid_o, 1);
    #2 arstn_i = 0;
    #1 rst_checks("mid");
    bq.delete();
    infl  = 0;
    mcnt  = 0;
    mcnt4 = 0;
    clear_logs();
    tick(1);
    #2 arstn_i = 1;
    tick(8);
    chk("rst_n", dlog.size(), 2);
    chk("rst_first", dlog[0], 8'hC5);
    chk("rst_second", dlog[1], 8'hC6);
    chk("rst_cnt", cnt_o, 2);
    chk("rst_cnt_c4", cnt4, 2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
